matrix_entry_controller: RTL and testbench
==========================================

MATRIX_ENTRY_CONTROLLER -- requirements
Module: matrix_entry_controller

Interface
REQ-001 The block SHALL have parameter N_ELEMS, default 16, meaning elements per matrix (2..16).
REQ-002 The block SHALL have parameter DEBOUNCE, default 16, meaning stable cycles before an enter level change is accepted (>=1).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles spent waiting for calc_done.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset. Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous reset, active-high
- enter  in  1  synchronized enter button level
- sw  in  1  synchronized restart button level
- operation  in  2  synchronized operation select
- data_in  in  8  synchronized element value
- calc_done  in  1  datapath completion pulse
- calc_error  in  1  datapath error flag, valid with calc_done
- wr_en  out  1  element write strobe
- wr_sel  out  1  0 = matrix A, 1 = matrix B
- wr_addr  out  4  element address
- wr_data  out  8  element value
- op  out  2  latched operation
- start  out  1  compute start pulse
- index  out  4  element index for display
- state_o  out  3  current state code
- finish  out  1  result available
- error  out  1  error indicator

Function
REQ-005 A press SHALL be accepted once, on the cycle enter has been high for DEBOUNCE consecutive cycles. After that, no further press is accepted until enter has been low for DEBOUNCE consecutive cycles.
REQ-006 A restart event SHALL be the first cycle on which sw is high after a cycle on which it was low (rising edge, no debounce).
REQ-007 States and state_o codes SHALL be: LOAD_A=0, LOAD_B=1, OP_SEL=2, START=3, WAIT=4, SHOW=5, ERR=6.
REQ-008 In LOAD_A and LOAD_B, an accepted press SHALL produce one cycle of wr_en=1 on the following cycle, with:
- wr_sel = 0 in LOAD_A, 1 in LOAD_B
- wr_addr = the current element counter
- wr_data = data_in sampled on the accept cycle
The element counter SHALL then increment.
REQ-009 The press that writes address N_ELEMS-1 SHALL move LOAD_A to LOAD_B, or LOAD_B to OP_SEL, and clear the element counter to 0.
REQ-010 In OP_SEL, an accepted press SHALL latch operation into op and move to START.
REQ-011 START SHALL last exactly one cycle with start=1, then move to WAIT. start SHALL be 0 in every other state.
REQ-012 In WAIT, a timeout counter SHALL increment each cycle. Exits:
- calc_done=1 with calc_error=0: move to SHOW, counter cleared.
- calc_done=1 with calc_error=1: move to ERR.
- counter reaches TIMEOUT-1 without calc_done: move to ERR.
- calc_done on the timeout cycle: calc_done wins.
REQ-013 In SHOW, finish SHALL be 1. Each accepted press SHALL increment the element counter, wrapping from N_ELEMS-1 to 0.
REQ-014 In ERR, error SHALL be 1. Presses SHALL be ignored. Only a restart event or rst exits ERR.
REQ-015 A restart event in any state SHALL move to LOAD_A with the element counter at 0. It SHALL take priority over a press or calc_done on the same cycle, and SHALL suppress that cycle's write.
REQ-016 In LOAD_A, LOAD_B and SHOW, index SHALL equal the element counter; in all other states index SHALL be 0.
REQ-017 In OP_SEL, START and WAIT, presses SHALL NOT write. Presses in START and WAIT SHALL be ignored.
REQ-018 op SHALL hold its latched value until the next OP_SEL latch or rst.

Reset
REQ-019 While rst=1, the block SHALL hold:
- state = LOAD_A, element counter = 0
- debounce and timeout counters = 0, press re-arm cleared
- wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, op=0, start=0, index=0, finish=0, error=0
- state_o=0
REQ-020 rst asserted mid-operation (including during a wr_en or start cycle) SHALL abort immediately, with no write or start completing.

Verification
REQ-021 Bench scenario, full load: N_ELEMS=4, DEBOUNCE=2. Press with data 1..4, then 5..8, then operation=2 -> wr_en pulses:
- (sel0, addr0..3, data1..4)
- (sel1, addr0..3, data5..8)
Then op=2, one start pulse, state_o=4.
REQ-022 Bench scenario, debounce and glitch: enter high 1 cycle then low, then high 10 cycles -> exactly one write. A second write occurs only after enter is low >=DEBOUNCE cycles and high again.
REQ-023 Bench scenario, completion paths: in WAIT, calc_done with calc_error=0 -> SHOW, finish=1. Presses give index 0,1,2,3,0.
REQ-024 Bench scenario, error paths:
- calc_done with calc_error=1 -> ERR, error=1; presses ignored.
- TIMEOUT=8 with no calc_done -> ERR exactly 8 cycles after entering WAIT.
REQ-025 Bench scenario, restart priority: sw rising edge on the same cycle as an accepted press in LOAD_B addr 2 -> no write, state_o=0, index=0.
REQ-026 Bench scenario, asynchronous reset: rst pulse between clock edges during the start cycle -> start drops immediately and all outputs take their REQ-019 values.

Source files
------------

// File: rtl/matrix_entry_controller.sv
// rtl/matrix_entry_controller.sv - matrix A/B element entry, operation select and compute handshake
module matrix_entry_controller #(
  parameter int N_ELEMS  = 16,
  parameter int DEBOUNCE = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       sw,
  input  logic [1:0] operation,
  input  logic [7:0] data_in,
  input  logic       calc_done,
  input  logic       calc_error,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [1:0] op,
  output logic       start,
  output logic [3:0] index,
  output logic [2:0] state_o,
  output logic       finish,
  output logic       error
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    ELEM_LAST = 4'(N_ELEMS - 1);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_OP_SEL = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_SHOW   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t        state, state_d;
  logic [3:0]    elem, elem_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          wr_en_d, wr_sel_d;
  logic [3:0]    wr_addr_d;
  logic [7:0]    wr_data_d;
  logic [1:0]    op_d;

  // Debounce: while unlatched we count consecutive high cycles, while latched
  // (press taken, waiting for release) we count consecutive low cycles.
  logic          deb_latched;
  logic [DW-1:0] deb_cnt;
  logic          level_match;
  logic          deb_hit;
  logic          press;

  assign level_match = enter ^ deb_latched;
  assign deb_hit     = level_match && (deb_cnt == DEB_LAST);
  assign press       = deb_hit && !deb_latched;

  // Debounce counter and release latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt     <= '0;
      deb_latched <= 1'b0;
    end else if (!level_match) begin
      deb_cnt <= '0;
    end else if (deb_hit) begin
      deb_cnt     <= '0;
      deb_latched <= ~deb_latched;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Restart edge detector; sw is treated as low before the first sampled cycle
  logic sw_q;
  logic restart;

  assign restart = sw && !sw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_q <= 1'b0;
    else     sw_q <= sw;
  end

  // State, counters and registered write/op outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD_A;
      elem    <= '0;
      tcnt    <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      op      <= '0;
    end else begin
      state   <= state_d;
      elem    <= elem_d;
      tcnt    <= tcnt_d;
      wr_en   <= wr_en_d;
      wr_sel  <= wr_sel_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      op      <= op_d;
    end
  end

  // Next-state logic; restart overrides everything including a same-cycle press
  always_comb begin
    state_d   = state;
    elem_d    = elem;
    tcnt_d    = '0;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    op_d      = op;
    if (restart) begin
      state_d = S_LOAD_A;
      elem_d  = '0;
    end else begin
      case (state)
        S_LOAD_A, S_LOAD_B: begin
          if (press) begin
            wr_en_d   = 1'b1;
            wr_sel_d  = (state == S_LOAD_B);
            wr_addr_d = elem;
            wr_data_d = data_in;
            if (elem == ELEM_LAST) begin
              elem_d  = '0;
              state_d = (state == S_LOAD_A) ? S_LOAD_B : S_OP_SEL;
            end else begin
              elem_d = elem + 4'd1;
            end
          end
        end
        S_OP_SEL: begin
          if (press) begin
            op_d    = operation;
            state_d = S_START;
          end
        end
        S_START: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (calc_done) begin
            state_d = calc_error ? S_ERR : S_SHOW;
            elem_d  = '0;
          end else if (tcnt == TO_LAST) begin
            state_d = S_ERR;
          end else begin
            tcnt_d = tcnt + TW'(1);
          end
        end
        S_SHOW: begin
          if (press) elem_d = (elem == ELEM_LAST) ? 4'd0 : elem + 4'd1;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_LOAD_A;
          elem_d  = '0;
        end
      endcase
    end
  end

  assign state_o = state;
  assign start   = (state == S_START);
  assign finish  = (state == S_SHOW);
  assign error   = (state == S_ERR);
  assign index   = (state == S_LOAD_A || state == S_LOAD_B || state == S_SHOW) ? elem : 4'd0;

endmodule

// File: tb/tb_matrix_entry_controller.sv
// tb/tb_matrix_entry_controller.sv - scoreboard bench for matrix_entry_controller
module tb_matrix_entry_controller;

  localparam int N = 4;
  localparam int D = 2;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enter, sw, calc_done, calc_error;
  logic [1:0] operation;
  logic [7:0] data_in;
  logic       wr_en, wr_sel, start, finish, error;
  logic [3:0] wr_addr, index;
  logic [7:0] wr_data;
  logic [1:0] op;
  logic [2:0] state_o;

  matrix_entry_controller #(.N_ELEMS(N), .DEBOUNCE(D), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .enter(enter), .sw(sw), .operation(operation),
    .data_in(data_in), .calc_done(calc_done), .calc_error(calc_error),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .op(op), .start(start), .index(index), .state_o(state_o),
    .finish(finish), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] sq[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_wr = 0;

  // Reference model: abstract phase, element counter, latched op, press armed
  int m_state, m_cnt, m_op;
  bit m_armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted press as seen by the rules: load phases write then advance
  task automatic model_press(input logic [7:0] d);
    wr_t e;
    case (m_state)
      0, 1: begin
        e.sel = (m_state == 1); e.addr = 4'(m_cnt); e.data = d;
        wq.push_back(e);
        if (m_cnt == N - 1) begin m_cnt = 0; m_state++; end
        else m_cnt++;
      end
      2: begin
        m_op = int'(operation);
        sq.push_back(operation);
        m_state = 4;
      end
      5: m_cnt = (m_cnt + 1) % N;
      default: ;
    endcase
  endtask

  // Drive enter at one level for len cycles; a high run of >=D while armed is a press
  task automatic drive_run(input logic level, input int len, input logic [7:0] d);
    enter = level;
    data_in = d;
    if (level) begin
      if (m_armed && len >= D) begin
        model_press(d);
        m_armed = 0;
      end
      if (len >= D) begin
        repeat (D) tick();
        data_in = 8'($urandom);
        repeat (len - D) tick();
      end else begin
        repeat (len) tick();
      end
    end else begin
      if (len >= D) m_armed = 1;
      repeat (len) tick();
    end
  endtask

  task automatic press(input logic [7:0] d);
    drive_run(1'b1, D + int'($urandom_range(0, 2)), d);
    drive_run(1'b0, D + int'($urandom_range(0, 2)), 8'($urandom));
  endtask

  task automatic op_press(input logic [1:0] o);
    operation = o;
    drive_run(1'b1, D, 8'($urandom));
    enter = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int exp_idx;
    exp_idx = (m_state == 0 || m_state == 1 || m_state == 5) ? m_cnt : 0;
    check({tag, "_state"}, state_o, m_state);
    check({tag, "_index"}, index, exp_idx);
    check({tag, "_finish"}, finish, (m_state == 5));
    check({tag, "_error"}, error, (m_state == 6));
    check({tag, "_op"}, op, m_op);
  endtask

  task automatic restart();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    m_state = 0;
    m_cnt = 0;
    check_state("restart");
  endtask

  // kind 0: done ok at WAIT cycle k, 1: done with error at k, 2: no done (timeout)
  task automatic complete(input int kind, input int k);
    if (kind < 2) begin
      repeat (1 + k) tick();
      check("in_wait", state_o, 4);
      calc_done = 1'b1;
      calc_error = (kind == 1);
      tick();
      calc_done = 1'b0;
      calc_error = 1'($urandom);
      m_state = (kind == 1) ? 6 : 5;
      m_cnt = 0;
    end else begin
      repeat (T) tick();
      check("wait_before_timeout", state_o, 4);
      tick();
      check("timeout_err", state_o, 6);
      m_state = 6;
    end
    check_state("complete");
    drive_run(1'b0, D, 8'($urandom));
  endtask

  task automatic load_random();
    for (int i = 0; i < 2 * N; i++) begin
      operation = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        drive_run(1'b1, 1, 8'($urandom));
        drive_run(1'b0, D, 8'($urandom));
      end
      press(8'($urandom));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_sel"}, wr_sel, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_index"}, index, 0);
    check({tag, "_state_o"}, state_o, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Monitor: every write and start pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wr_en) begin
        n_wr++;
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%0d expected none", wr_sel, wr_addr, wr_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_sel", wr_sel, e.sel);
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
      end
      if (start) begin
        if (sq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_start: got start=1 op=%0d expected none", op);
        end else begin
          logic [1:0] eo;
          eo = sq.pop_front();
          check("start_op", op, eo);
          check("start_state", state_o, 3);
        end
      end
    end
  end

  initial begin
    int w0;
    rst = 1'b1; enter = 1'b0; sw = 1'b0; operation = 2'd0; data_in = 8'd0;
    calc_done = 1'b0; calc_error = 1'b0;
    m_state = 0; m_cnt = 0; m_op = 0; m_armed = 1;
    #2;
    check_reset_outs("rst_initial");
    enter = 1'b1; sw = 1'b1; data_in = 8'hA5;
    repeat (4) tick();
    check_reset_outs("rst_held");
    enter = 1'b0; sw = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_state("post_reset");

    // Glitch then long press, short release, then proper release and press
    w0 = n_wr;
    drive_run(1'b1, 1, 8'd11);
    drive_run(1'b0, 2, 8'd0);
    drive_run(1'b1, 10, 8'd22);
    drive_run(1'b0, 1, 8'd0);
    drive_run(1'b1, 3, 8'd33);
    drive_run(1'b0, 3, 8'd0);
    drive_run(1'b1, 2, 8'd44);
    drive_run(1'b0, 2, 8'd0);
    check("glitch_write_count", n_wr - w0, 2);
    check_state("glitch");
    restart();

    // Full load with data 1..8, operation 2, then successful completion
    drive_run(1'b1, D, 8'd1);
    check("wr_latency", wr_en, 1);
    drive_run(1'b0, D, 8'd0);
    for (int i = 2; i <= 2 * N; i++) press(8'(i));
    check_state("loaded");
    op_press(2'd2);
    check("start_pulse", start, 1);
    check("start_code", state_o, 3);
    complete(0, 2);
    for (int i = 0; i < N + 1; i++) begin
      press(8'($urandom));
      check_state("show_press");
    end
    restart();

    // Error via calc_error, presses ignored
    load_random();
    op_press(2'($urandom));
    complete(1, int'($urandom_range(0, T - 1)));
    press(8'($urandom));
    press(8'($urandom));
    check_state("err_ignore");
    restart();

    // Timeout, then calc_done on the final timeout cycle
    load_random();
    op_press(2'($urandom));
    complete(2, 0);
    restart();
    load_random();
    op_press(2'($urandom));
    complete(0, T - 1);
    restart();

    // Restart coincident with accepted press at LOAD_B addr 2
    for (int i = 0; i < N + 2; i++) press(8'($urandom));
    check_state("pre_restart_b2");
    enter = 1'b1; data_in = 8'h77;
    tick();
    sw = 1'b1;
    tick();
    check("restart_no_wr", wr_en, 0);
    m_armed = 0; m_state = 0; m_cnt = 0;
    check_state("restart_prio");
    sw = 1'b0;
    drive_run(1'b0, D, 8'd0);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      int kind;
      check("op_hold", op, m_op);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2 * N - 1)) press(8'($urandom));
        restart();
      end
      load_random();
      op_press(2'($urandom));
      kind = int'($urandom_range(0, 2));
      complete(kind, int'($urandom_range(0, T - 1)));
      repeat ($urandom_range(1, 6)) begin
        press(8'($urandom));
        check_state("rand_post");
      end
      restart();
    end

    // Asynchronous reset during a write cycle
    drive_run(1'b1, D, 8'h5A);
    check("pre_rst_wr", wr_en, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outs("async_rst_wr");
    void'(wq.pop_back());
    enter = 1'b0;
    tick();
    rst = 1'b0;
    m_state = 0; m_cnt = 0; m_op = 0; m_armed = 1;
    drive_run(1'b0, D, 8'd0);

    // Asynchronous reset during the start cycle
    for (int i = 0; i < 2 * N; i++) press(8'($urandom));
    op_press(2'd3);
    check("pre_rst_start", start, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outs("async_rst_start");
    void'(sq.pop_back());
    tick();
    rst = 1'b0;
    m_state = 0; m_cnt = 0; m_op = 0; m_armed = 1;
    drive_run(1'b0, D, 8'd0);
    check_state("after_async");

    check("wq_drained", wq.size(), 0);
    check("sq_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
